// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot loader that writes a checksummed byte frame into instruction memory
// Frame format: length N (0 means 256), N instruction bytes, then the 8-bit sum of those bytes.
// Ports:
//   i_clk, i_reset (async, active low), i_start
//   i_in_valid, i_in_data, o_in_ready             byte stream handshake
//   o_mem_we, o_mem_addr, o_mem_wdata             instruction memory write port
//   o_cpu_reset, o_busy, o_done, o_error          core reset and load status
module instr_mem_loader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 8
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_start,
   input  logic              i_in_valid,
   input  logic [DATA_W-1:0] i_in_data,
   output logic              o_in_ready,
   output logic              o_mem_we,
   output logic [ADDR_W-1:0] o_mem_addr,
   output logic [DATA_W-1:0] o_mem_wdata,
   output logic              o_cpu_reset,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_error
);
   typedef enum logic [2:0] {S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR} state_t;
   state_t r_state, w_next;
   logic [ADDR_W:0] r_len, r_addr, w_len;
   logic [DATA_W-1:0] r_sum;
   logic w_acc, w_last;
   assign w_acc  = i_in_valid & o_in_ready;
   // a length byte of zero encodes a full 2^ADDR_W image
   assign w_len  = (i_in_data == '0) ? {1'b1, {ADDR_W{1'b0}}} : (ADDR_W+1)'(i_in_data);
   // the address counter is one bit wider so index 255 is recognised as last without wrapping
   assign w_last = (r_addr + 1'b1) == r_len;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE, S_DONE, S_ERR: w_next = i_start ? S_LEN : r_state;
         S_LEN:  w_next = w_acc ? S_DATA : r_state;
         S_DATA: w_next = (w_acc && w_last) ? S_CSUM : r_state;
         S_CSUM: w_next = w_acc ? ((i_in_data == r_sum) ? S_DONE : S_ERR) : r_state;
         default: w_next = S_IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the new state
   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_len       <= '0;
         r_addr      <= '0;
         r_sum       <= '0;
         o_in_ready  <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
         o_cpu_reset <= 1'b1;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_error     <= 1'b0;
      end else begin
         r_state     <= w_next;
         o_in_ready  <= w_next inside {S_LEN, S_DATA, S_CSUM};
         o_busy      <= w_next inside {S_LEN, S_DATA, S_CSUM};
         o_done      <= w_next == S_DONE;
         o_error     <= w_next == S_ERR;
         o_cpu_reset <= w_next != S_DONE;
         o_mem_we    <= w_acc && r_state == S_DATA;
         if (w_acc && r_state == S_LEN) begin
            r_len  <= w_len;
            r_addr <= '0;
            r_sum  <= '0;
         end
         if (w_acc && r_state == S_DATA) begin
            o_mem_addr  <= r_addr[ADDR_W-1:0];
            o_mem_wdata <= i_in_data;
            r_sum       <= r_sum + i_in_data;
            r_addr      <= r_addr + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_instr_mem_loader.sv
// tb_instr_mem_loader: randomized frame loads checked against a queue-based model of expected writes
module tb_instr_mem_loader;
   logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
   logic [7:0] in_data = '0;
   logic in_ready, mem_we, cpu_reset, busy, done, error;
   logic [7:0] mem_addr, mem_wdata;
   int errs = 0, checks = 0;
   logic [15:0] wq[$];
   logic [7:0] fr[$];

   instr_mem_loader dut (
      .i_clk(clk), .i_reset(rst_n), .i_start(start), .i_in_valid(in_valid), .i_in_data(in_data),
      .o_in_ready(in_ready), .o_mem_we(mem_we), .o_mem_addr(mem_addr), .o_mem_wdata(mem_wdata),
      .o_cpu_reset(cpu_reset), .o_busy(busy), .o_done(done), .o_error(error)
   );

   always #5 clk = ~clk;
   always @(negedge clk) if (mem_we) wq.push_back({mem_addr, mem_wdata});

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start;
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      check("start_ready", in_ready, 1);
      check("start_busy", busy, 1);
      check("start_cpu_rst", cpu_reset, 1);
      check("start_done", done, 0);
      check("start_error", error, 0);
   endtask

   // offers bytes of b until limit are accepted; returns with time just after the last accepting edge
   task automatic send(input logic [7:0] b[$], input int limit, input bit gaps, input bit spam, output int k);
      int cyc = 0;
      bit v, acc;
      k = 0;
      while (k < limit && cyc < 4000) begin
         @(negedge clk);
         v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         in_valid = v;
         in_data = b[k];
         start = spam ? 1'($urandom_range(0, 1)) : 1'b0;
         acc = v && in_ready;
         @(posedge clk);
         if (acc) k++;
         cyc++;
      end
      #1;
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic load(input bit bad, input bit gaps, input bit spam);
      logic [7:0] b[$];
      logic [7:0] sum = '0;
      int n = fr.size(), k;
      b.push_back(n[7:0]);
      foreach (fr[i]) begin
         b.push_back(fr[i]);
         sum += fr[i];
      end
      b.push_back(bad ? sum + 8'd1 : sum);
      pulse_start();
      wq.delete();
      send(b, b.size(), gaps, spam, k);
      check("accepted", k, b.size());
      check("done", done, !bad);
      check("error", error, bad);
      check("cpu_reset", cpu_reset, bad);
      check("busy_end", busy, 0);
      check("ready_end", in_ready, 0);
      check("nwrites", wq.size(), n);
      for (int i = 0; i < n && i < wq.size(); i++) check("write", wq[i], {i[7:0], fr[i]});
   endtask

   task automatic idle_spam(input logic exp_done);
      int n0 = wq.size();
      repeat (4) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data = 8'($urandom);
         check("idle_ready", in_ready, 0);
      end
      @(negedge clk);
      in_valid = 1'b0;
      check("idle_nowrite", wq.size(), n0);
      check("idle_busy", busy, 0);
      check("idle_done", done, exp_done);
   endtask

   initial begin
      logic [7:0] b[$];
      int k;
      #12;
      check("rst_ready", in_ready, 0);
      check("rst_we", mem_we, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_wdata", mem_wdata, 0);
      check("rst_cpu", cpu_reset, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      @(negedge clk) rst_n = 1'b1;
      idle_spam(0);
      fr = '{8'h12, 8'h34, 8'h56};
      load(0, 0, 0);
      idle_spam(1);
      load(1, 0, 0);
      load(0, 0, 0);
      fr.delete();
      for (int i = 0; i < 256; i++) fr.push_back(i[7:0]);
      load(0, 0, 0);
      fr.delete();
      repeat (4) fr.push_back(8'($urandom));
      load(0, 1, 0);
      load(0, 1, 1);
      // reset mid-load after the second data byte of a five-byte frame
      fr.delete();
      repeat (5) fr.push_back(8'($urandom));
      b = '{8'd5};
      foreach (fr[i]) b.push_back(fr[i]);
      pulse_start();
      wq.delete();
      send(b, 3, 0, 0, k);
      #1 rst_n = 1'b0;
      #1;
      check("mid_we", mem_we, 0);
      check("mid_ready", in_ready, 0);
      check("mid_addr", mem_addr, 0);
      check("mid_wdata", mem_wdata, 0);
      check("mid_cpu", cpu_reset, 1);
      check("mid_busy", busy, 0);
      @(negedge clk) rst_n = 1'b1;
      check("mid_nwrites", wq.size(), 1);
      idle_spam(0);
      repeat (8) begin
         int n = $urandom_range(1, 40);
         fr.delete();
         repeat (n) fr.push_back(8'($urandom));
         load(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
